omsp_sm_control_v2: RTL and testbench

Parametrised successor to the protected-module control block. It owns slot allocation, ID issue and executing-ID history for NB_SMS protected-module slots, using a request/response create/destroy handshake with an explicit overlap-check cycle. Destroy is by target ID rather than broadcast. Sits between the execution unit's protected-module instruction decode and the per-slot range-check instances, which feed enabled/executing/violation/id vectors back in.

---
 rtl/omsp_sm_control_v2.sv | 208 ++++++++++++++++++++
 tb/tb_omsp_sm_control_v2.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/omsp_sm_control_v2.sv
`timescale 1ns/1ps
// Protected-module control: slot allocation, ID issue, create/destroy handshake
// with an overlap-check cycle, and the history of executing module IDs.
module omsp_sm_control_v2 #(
    parameter int NB_SMS     = 4,
    parameter int ID_W       = 16,
    parameter int IRQ_W      = 4,
    parameter int HIST_DEPTH = 2,
    parameter logic [ID_W-1:0] IRQ_ID_BASE = ID_W'((64'd1 << ID_W) - (64'd1 << IRQ_W)),
    localparam int SLOT_W    = (NB_SMS > 1) ? $clog2(NB_SMS) : 1
) (
    input  logic                       mclk,
    input  logic                       puc_rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [ID_W-1:0]            req_target_id,
    output logic                       rsp_valid,
    output logic [1:0]                 rsp_status,
    output logic [SLOT_W-1:0]          rsp_slot,
    output logic [ID_W-1:0]            rsp_id,
    input  logic [NB_SMS-1:0]          slot_enabled,
    input  logic [NB_SMS-1:0]          slot_executing,
    input  logic [NB_SMS-1:0]          slot_violation,
    input  logic [NB_SMS*ID_W-1:0]     slot_id,
    output logic [NB_SMS-1:0]          slot_update,
    output logic                       slot_enable,
    output logic [NB_SMS-1:0]          slot_check,
    output logic [ID_W-1:0]            next_id,
    input  logic                       handling_irq,
    input  logic [IRQ_W-1:0]           irq_num,
    output logic [ID_W-1:0]            current_id,
    output logic [ID_W-1:0]            prev_id,
    output logic [HIST_DEPTH*ID_W-1:0] id_hist,
    output logic                       sm_executing,
    output logic                       violation
);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_COMMIT, S_DESTROY, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   target_q, target_d;
    logic [ID_W-1:0]   next_id_q, next_id_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [SLOT_W-1:0] free_q, free_d;
    logic [SLOT_W-1:0] rsp_slot_q, rsp_slot_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic [ID_W-1:0]   last_id_q;
    logic [ID_W-1:0]   hist_q [HIST_DEPTH];

    logic [ID_W-1:0]   ids [NB_SMS];
    logic [SLOT_W-1:0] free_idx, match_idx, exec_idx;
    logic              free_found, match_found, exec_found;
    logic [NB_SMS-1:0] free_onehot, match_onehot;

    for (genvar gi = 0; gi < NB_SMS; gi++) begin : g_ids
        assign ids[gi] = slot_id[gi*ID_W +: ID_W];
    end

    // Descending scan so the last hit is the lowest index.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        match_found = 1'b0;
        match_idx   = '0;
        exec_found  = 1'b0;
        exec_idx    = '0;
        for (int k = NB_SMS - 1; k >= 0; k--) begin
            if (!slot_enabled[k]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(k);
            end
            if (slot_enabled[k] && (ids[k] == target_q)) begin
                match_found = 1'b1;
                match_idx   = SLOT_W'(k);
            end
            if (slot_executing[k]) begin
                exec_found = 1'b1;
                exec_idx   = SLOT_W'(k);
            end
        end
    end

    assign free_onehot  = NB_SMS'(1) << free_q;
    assign match_onehot = NB_SMS'(1) << match_idx;

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        free_d       = free_q;
        next_id_d    = next_id_q;
        rsp_status_d = rsp_status_q;
        rsp_slot_d   = rsp_slot_q;
        rsp_id_d     = rsp_id_q;
        req_ready    = 1'b0;
        slot_update  = '0;
        slot_enable  = 1'b0;
        slot_check   = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    target_d = req_target_id;
                    free_d   = free_idx;
                    if (req_op == 2'b01) begin
                        if (next_id_q == IRQ_ID_BASE) begin
                            state_d = S_RESP; rsp_status_d = 2'd3; rsp_slot_d = '0; rsp_id_d = '0;
                        end else if (!free_found) begin
                            state_d = S_RESP; rsp_status_d = 2'd1; rsp_slot_d = '0; rsp_id_d = '0;
                        end else begin
                            state_d = S_CHECK;
                        end
                    end else if (req_op == 2'b10) begin
                        state_d = S_DESTROY;
                    end else begin
                        state_d = S_RESP; rsp_status_d = 2'd3; rsp_slot_d = '0; rsp_id_d = '0;
                    end
                end
            end
            S_CHECK: begin
                slot_check = slot_enabled & ~free_onehot;
                if (|slot_violation) begin
                    state_d = S_RESP; rsp_status_d = 2'd2; rsp_slot_d = free_q; rsp_id_d = '0;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                slot_update  = free_onehot;
                slot_enable  = 1'b1;
                next_id_d    = next_id_q + ID_W'(1);
                state_d      = S_RESP;
                rsp_status_d = 2'd0;
                rsp_slot_d   = free_q;
                rsp_id_d     = next_id_q;
            end
            S_DESTROY: begin
                state_d = S_RESP;
                if (match_found && (target_q != '0)) begin
                    slot_update  = match_onehot;
                    rsp_status_d = 2'd0;
                    rsp_slot_d   = match_idx;
                    rsp_id_d     = target_q;
                end else begin
                    rsp_status_d = 2'd3; rsp_slot_d = '0; rsp_id_d = '0;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q      <= S_IDLE;
            target_q     <= '0;
            free_q       <= '0;
            next_id_q    <= ID_W'(1);
            rsp_status_q <= '0;
            rsp_slot_q   <= '0;
            rsp_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            free_q       <= free_d;
            next_id_q    <= next_id_d;
            rsp_status_q <= rsp_status_d;
            rsp_slot_q   <= rsp_slot_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    always_comb begin
        current_id = '0;
        if (handling_irq)
            current_id = IRQ_ID_BASE + ID_W'(irq_num);
        else if (exec_found)
            current_id = ids[exec_idx];
    end

    // History shifts only when the executing ID changes.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            last_id_q <= '0;
            for (int k = 0; k < HIST_DEPTH; k++) hist_q[k] <= '0;
        end else begin
            last_id_q <= current_id;
            if (last_id_q != current_id) begin
                hist_q[0] <= last_id_q;
                for (int k = 1; k < HIST_DEPTH; k++) hist_q[k] <= hist_q[k-1];
            end
        end
    end

    for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
        assign id_hist[gi*ID_W +: ID_W] = hist_q[gi];
    end

    assign prev_id      = hist_q[0];
    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_status   = rsp_status_q;
    assign rsp_slot     = rsp_slot_q;
    assign rsp_id       = rsp_id_q;
    assign next_id      = next_id_q;
    assign sm_executing = |slot_executing;
    assign violation    = ((|slot_violation) && (state_q != S_CHECK)) || (next_id_q == IRQ_ID_BASE);

endmodule

// File: tb/tb_omsp_sm_control_v2.sv
`timescale 1ns/1ps
// Scoreboard bench for omsp_sm_control_v2 at reduced widths (ID_W=6, IRQ_W=2):
// the driver predicts each response/strobe, a negedge monitor pops and compares.
module tb_omsp_sm_control_v2;
    localparam int NB   = 4;
    localparam int IDW  = 6;
    localparam int IRQW = 2;
    localparam int HD   = 2;
    localparam int BASE = (1 << IDW) - (1 << IRQW);

    logic            mclk = 1'b0;
    logic            puc_rst_n;
    logic            req_valid, req_ready;
    logic [1:0]      req_op;
    logic [IDW-1:0]  req_target_id;
    logic            rsp_valid;
    logic [1:0]      rsp_status;
    logic [1:0]      rsp_slot;
    logic [IDW-1:0]  rsp_id;
    logic [NB-1:0]   slot_enabled, slot_executing, slot_violation;
    logic [NB*IDW-1:0] slot_id;
    logic [NB-1:0]   slot_update, slot_check;
    logic            slot_enable;
    logic [IDW-1:0]  next_id, current_id, prev_id;
    logic            handling_irq;
    logic [IRQW-1:0] irq_num;
    logic [HD*IDW-1:0] id_hist;
    logic            sm_executing, violation;

    logic [IDW-1:0]  sid [NB];
    assign slot_id = {sid[3], sid[2], sid[1], sid[0]};

    omsp_sm_control_v2 #(.NB_SMS(NB), .ID_W(IDW), .IRQ_W(IRQW), .HIST_DEPTH(HD)) dut (
        .mclk(mclk), .puc_rst_n(puc_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_target_id(req_target_id),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_slot(rsp_slot), .rsp_id(rsp_id),
        .slot_enabled(slot_enabled), .slot_executing(slot_executing), .slot_violation(slot_violation),
        .slot_id(slot_id), .slot_update(slot_update), .slot_enable(slot_enable), .slot_check(slot_check),
        .next_id(next_id), .handling_irq(handling_irq), .irq_num(irq_num),
        .current_id(current_id), .prev_id(prev_id), .id_hist(id_hist),
        .sm_executing(sm_executing), .violation(violation)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    typedef struct {int c; logic [1:0] st; bit pay; logic [1:0] sl; logic [IDW-1:0] id;} rsp_t;
    typedef struct {int c; logic [NB-1:0] upd; logic en; logic [NB-1:0] chk;} str_t;
    rsp_t rsp_q[$];
    str_t str_q[$];
    int   errors = 0;
    int   checks = 0;
    int   m_next_id = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_line(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen as required (cycle %0d)", name, cyc);
    endtask

    // Reference executing ID straight from the driven inputs.
    function automatic logic [IDW-1:0] ref_cur();
        if (handling_irq) return IDW'(BASE + int'(irq_num));
        for (int k = 0; k < NB; k++) if (slot_executing[k]) return sid[k];
        return '0;
    endfunction

    // History model: list of superseded IDs, newest first.
    logic [IDW-1:0] changes[$];
    logic [IDW-1:0] m_last = '0;
    initial forever begin
        @(posedge mclk or negedge puc_rst_n);
        if (!puc_rst_n) begin
            changes.delete();
            m_last = '0;
        end else if (ref_cur() != m_last) begin
            changes.push_front(m_last);
            if (changes.size() > HD) void'(changes.pop_back());
            m_last = ref_cur();
        end
    end

    function automatic logic [HD*IDW-1:0] hist_exp();
        logic [HD*IDW-1:0] h = '0;
        for (int k = 0; k < HD; k++) if (k < changes.size()) h[k*IDW +: IDW] = changes[k];
        return h;
    endfunction

    // Monitor
    initial forever begin
        rsp_t r;
        str_t s;
        @(negedge mclk);
        if (puc_rst_n) begin
            while (rsp_q.size() > 0 && rsp_q[0].c < cyc) begin
                void'(rsp_q.pop_front());
                fail_line("rsp_missing");
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0 || rsp_q[0].c != cyc) fail_line("rsp_unexpected");
                else begin
                    r = rsp_q.pop_front();
                    chk("rsp_status", rsp_status, r.st);
                    if (r.pay) begin
                        chk("rsp_slot", rsp_slot, r.sl);
                        chk("rsp_id", rsp_id, r.id);
                    end
                    $display("rsp cyc=%0d status=%0d slot=%0d id=%0d", cyc, rsp_status, rsp_slot, rsp_id);
                end
            end
            while (str_q.size() > 0 && str_q[0].c < cyc) begin
                void'(str_q.pop_front());
                fail_line("strobe_missing");
            end
            if (str_q.size() > 0 && str_q[0].c == cyc) begin
                s = str_q.pop_front();
                chk("slot_update", slot_update, s.upd);
                chk("slot_enable", slot_enable, s.en);
                chk("slot_check", slot_check, s.chk);
            end else if (slot_update != 0 || slot_check != 0 || slot_enable) begin
                fail_line("strobe_unexpected");
            end
            chk("current_id", current_id, ref_cur());
            chk("sm_executing", sm_executing, |slot_executing);
            chk("prev_id", prev_id, hist_exp() & {IDW{1'b1}});
            chk("id_hist", id_hist, hist_exp());
        end
    end

    task automatic issue(input logic [1:0] op, input logic [IDW-1:0] tgt, input logic [NB-1:0] vp);
        int acc, fr, mt;
        bit to_check;
        @(posedge mclk); #1;
        chk("req_ready", req_ready, 1'b1);
        acc = cyc;
        fr = -1;
        mt = -1;
        to_check = 0;
        for (int k = NB - 1; k >= 0; k--) begin
            if (!slot_enabled[k]) fr = k;
            if (slot_enabled[k] && sid[k] == tgt) mt = k;
        end
        if (op == 2'b01) begin
            if (m_next_id == BASE) rsp_q.push_back('{acc + 1, 2'd3, 1'b0, 2'd0, '0});
            else if (fr < 0) rsp_q.push_back('{acc + 1, 2'd1, 1'b0, 2'd0, '0});
            else begin
                to_check = 1;
                str_q.push_back('{acc + 1, '0, 1'b0, slot_enabled & ~NB'(1 << fr)});
                if (vp != 0) rsp_q.push_back('{acc + 2, 2'd2, 1'b0, 2'd0, '0});
                else begin
                    str_q.push_back('{acc + 2, NB'(1 << fr), 1'b1, '0});
                    rsp_q.push_back('{acc + 3, 2'd0, 1'b1, 2'(fr), IDW'(m_next_id)});
                    m_next_id++;
                end
            end
        end else if (op == 2'b10) begin
            if (tgt != 0 && mt >= 0) begin
                str_q.push_back('{acc + 1, NB'(1 << mt), 1'b0, '0});
                rsp_q.push_back('{acc + 2, 2'd0, 1'b1, 2'(mt), tgt});
            end else rsp_q.push_back('{acc + 2, 2'd3, 1'b0, 2'd0, '0});
        end else begin
            rsp_q.push_back('{acc + 1, 2'd3, 1'b0, 2'd0, '0});
        end
        req_valid = 1'b1; req_op = op; req_target_id = tgt;
        @(posedge mclk); #1;
        req_valid = 1'b0; req_op = 2'b00;
        if (to_check && vp != 0) begin
            slot_violation = vp;
            #1;
            chk("violation_in_check", violation, 1'b0);
            @(posedge mclk); #1;
            slot_violation = '0;
        end
        for (int w = 0; w < 8 && (rsp_q.size() != 0 || str_q.size() != 0); w++) begin
            @(negedge mclk); #1;
        end
        if (rsp_q.size() != 0 || str_q.size() != 0) begin
            fail_line("drain_timeout");
            rsp_q.delete();
            str_q.delete();
        end
        chk("next_id", next_id, m_next_id);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int r;
        logic [1:0] op;
        logic [IDW-1:0] tgt;
        logic [NB-1:0] vp;
        puc_rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_target_id = '0;
        slot_enabled = '0; slot_executing = '0; slot_violation = '0;
        handling_irq = 1'b0; irq_num = '0;
        for (int k = 0; k < NB; k++) sid[k] = '0;
        repeat (3) @(posedge mclk);
        #1;
        chk("rst_next_id", next_id, 1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_status", rsp_status, 2'd0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_strobes", {slot_update, slot_check, slot_enable}, 0);
        chk("rst_prev_id", prev_id, 0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_violation", violation, 1'b0);
        puc_rst_n = 1'b1;

        // Basic create into empty table, then overlap, full, destroy cases.
        issue(2'b01, '0, '0);
        slot_enabled = 4'b0101;
        issue(2'b01, '0, 4'b0001);
        slot_enabled = 4'b1111;
        sid[0] = 6'd1; sid[1] = 6'd2; sid[2] = 6'd3; sid[3] = 6'd4;
        issue(2'b01, '0, '0);
        issue(2'b10, 6'd3, '0);
        issue(2'b10, 6'd9, '0);
        sid[0] = 6'd0;
        issue(2'b10, 6'd0, '0);
        slot_enabled = 4'b1011;
        issue(2'b10, 6'd3, '0);
        issue(2'b00, '0, '0);
        issue(2'b11, '0, '0);

        slot_violation = 4'b0100;
        #1;
        chk("violation_idle", violation, 1'b1);
        slot_violation = '0;

        for (int i = 0; i < 40; i++) begin
            slot_enabled = NB'($urandom);
            for (int k = 0; k < NB; k++) sid[k] = IDW'($urandom);
            r = $urandom_range(0, 9);
            op = (r < 5) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
            tgt = ($urandom_range(0, 1) == 1) ? sid[$urandom_range(0, NB - 1)] : IDW'($urandom);
            vp = ($urandom_range(0, 3) == 0) ? NB'($urandom_range(1, 15)) : '0;
            issue(op, tgt, vp);
        end

        // Executing-ID history.
        sid[0] = 6'd17; sid[1] = 6'd5;
        slot_executing = '0;
        repeat (3) @(posedge mclk);
        #1;
        slot_executing = 4'b0010;
        repeat (3) @(posedge mclk);
        #1;
        chk("hist_cur_slot1", current_id, 6'd5);
        chk("hist_prev_0", prev_id, 6'd0);
        handling_irq = 1'b1; irq_num = 2'd2;
        repeat (3) @(posedge mclk);
        #1;
        chk("hist_cur_irq", current_id, BASE + 2);
        chk("hist_prev_5", prev_id, 6'd5);
        handling_irq = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        chk("hist_prev_irq", prev_id, BASE + 2);
        chk("hist_entry1", id_hist[2*IDW-1:IDW], 6'd5);
        slot_executing = 4'b0011;
        #1;
        chk("hist_lowest_exec", current_id, 6'd17);
        for (int i = 0; i < 30; i++) begin
            @(posedge mclk); #1;
            slot_executing = NB'($urandom);
            handling_irq = ($urandom_range(0, 3) == 0);
            irq_num = IRQW'($urandom);
            for (int k = 0; k < NB; k++) if ($urandom_range(0, 4) == 0) sid[k] = IDW'($urandom);
        end
        handling_irq = 1'b0;

        // Reset while the create sits in its overlap-check cycle.
        slot_enabled = '0;
        @(posedge mclk); #1;
        req_valid = 1'b1; req_op = 2'b01;
        @(posedge mclk); #1;
        req_valid = 1'b0; req_op = 2'b00;
        puc_rst_n = 1'b0;
        #1;
        chk("midrst_update", slot_update, 0);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        repeat (2) @(posedge mclk);
        #1;
        puc_rst_n = 1'b1;
        m_next_id = 1;
        repeat (4) @(negedge mclk);
        #1;
        chk("midrst_next_id", next_id, 1);
        chk("midrst_req_ready", req_ready, 1'b1);

        // Drive next_id to saturation.
        slot_executing = '0;
        guard = 0;
        while (m_next_id < BASE && guard < 100) begin
            slot_enabled = NB'($urandom) & 4'b0111;
            issue(2'b01, '0, '0);
            guard++;
        end
        chk("sat_model_reached", m_next_id, BASE);
        @(posedge mclk); #1;
        chk("sat_violation", violation, 1'b1);
        slot_enabled = 4'b0000;
        issue(2'b01, '0, '0);
        issue(2'b01, '0, 4'b0010);
        chk("sat_next_id_hold", next_id, BASE);

        repeat (2) @(posedge mclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
